sklansky_subtractor_pipe: RTL and testbench

- Pipelined, handshaked unsigned/two's-complement subtractor built on a Sklansky parallel-prefix borrow tree.
- Computes Diff = A - B - Borrow_in. Internally this is A + ~B + ~Borrow_in, carried through the same generate/propagate prefix structure as the exact Sklansky adder, so results are bit-for-bit comparable against that adder.
- Sits downstream of operand sources in the AxPPA datapath and serves as the exact-subtract counterpart for error characterisation.

---
 rtl/sklansky_subtractor_pipe_if.sv | 27 ++
 rtl/sklansky_subtractor_pipe.sv | 125 ++++++++++++
 tb/tb_sklansky_subtractor_pipe.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/sklansky_subtractor_pipe_if.sv
// Operand/result handshake bundle for the Sklansky subtractor pipeline.
// Valid/ready: a beat transfers on a rising edge where valid & ready are both 1; the producer holds valid and data until then.
interface sklansky_subtractor_pipe_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH:1]   A;
  logic [WIDTH:1]   B;
  logic             Borrow_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH:1]   Diff;
  logic [WIDTH:0]   Borrow_Out;
  logic             Zero;
  logic             Overflow;

  modport master (
    output in_valid, A, B, Borrow_in, out_ready,
    input  in_ready, out_valid, Diff, Borrow_Out, Zero, Overflow
  );

  modport slave (
    input  in_valid, A, B, Borrow_in, out_ready,
    output in_ready, out_valid, Diff, Borrow_Out, Zero, Overflow
  );
endinterface

// File: rtl/sklansky_subtractor_pipe.sv
// Two-stage A - B - Borrow_in subtractor: computed as A + ~B + ~Borrow_in through a
// Sklansky prefix tree split across stages; all outputs are registered in stage 2.
module sklansky_subtractor_pipe #(
  parameter int WIDTH = 16,
  parameter int SPLIT = (WIDTH == 16) ? 2 : $clog2(WIDTH) / 2
) (
  input logic                       clk,
  input logic                       rst_n,
  sklansky_subtractor_pipe_if.slave bus
);
  localparam int L = $clog2(WIDTH);

  // One Sklansky level: bits in the upper half of each 2^j block absorb the top bit of the lower half.
  function automatic logic [2*WIDTH-1:0] prefix_level(input logic [WIDTH-1:0] p,
                                                      input logic [WIDTH-1:0] g,
                                                      input int               j);
    logic [WIDTH-1:0] po;
    logic [WIDTH-1:0] go;
    int               lo;
    po = p;
    go = g;
    for (int i = 0; i < WIDTH; i++) begin
      if (((i >> (j - 1)) & 1) == 1) begin
        lo    = ((i >> (j - 1)) << (j - 1)) - 1;
        po[i] = p[i] & p[lo];
        go[i] = g[i] | (p[i] & g[lo]);
      end
    end
    return {po, go};
  endfunction

  logic [WIDTH-1:0] w_a, w_b, w_bit_p, w_s1_p, w_s1_g;
  logic [WIDTH-1:0] w_s2_p, w_s2_g, w_carry, w_diff;
  logic [WIDTH:0]   w_bo;
  logic             w_zero, w_ovf;
  logic             w_in_acc, w_s2_free, w_s1_adv, w_in_ready;

  logic             r_s1_valid, r_s1_c0, r_s1_amsb, r_s1_bmsb;
  logic [WIDTH-1:0] r_s1_p1, r_s1_p, r_s1_g;
  logic             r_s2_valid, r_s2_zero, r_s2_ovf;
  logic [WIDTH-1:0] r_s2_diff;
  logic [WIDTH:0]   r_s2_bo;

  assign w_a = bus.A;
  assign w_b = bus.B;

  assign w_s2_free  = ~r_s2_valid | bus.out_ready;
  assign w_s1_adv   = r_s1_valid & w_s2_free;
  assign w_in_ready = ~r_s1_valid | w_s1_adv;
  assign w_in_acc   = bus.in_valid & w_in_ready;

  always_comb begin
    w_bit_p = w_a ^ ~w_b;
    w_s1_p  = w_bit_p;
    w_s1_g  = w_a & ~w_b;
    for (int j = 1; j <= SPLIT; j++) begin
      {w_s1_p, w_s1_g} = prefix_level(w_s1_p, w_s1_g, j);
    end
  end

  // Operand data is captured only on accept, so idle-cycle garbage never enters the pipe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_p1    <= '0;
      r_s1_p     <= '0;
      r_s1_g     <= '0;
      r_s1_c0    <= 1'b0;
      r_s1_amsb  <= 1'b0;
      r_s1_bmsb  <= 1'b0;
    end else begin
      if (w_in_acc) begin
        r_s1_valid <= 1'b1;
      end else if (w_s1_adv) begin
        r_s1_valid <= 1'b0;
      end
      if (w_in_acc) begin
        r_s1_p1   <= w_bit_p;
        r_s1_p    <= w_s1_p;
        r_s1_g    <= w_s1_g;
        r_s1_c0   <= ~bus.Borrow_in;
        r_s1_amsb <= w_a[WIDTH-1];
        r_s1_bmsb <= w_b[WIDTH-1];
      end
    end
  end

  always_comb begin
    w_s2_p = r_s1_p;
    w_s2_g = r_s1_g;
    for (int j = SPLIT + 1; j <= L; j++) begin
      {w_s2_p, w_s2_g} = prefix_level(w_s2_p, w_s2_g, j);
    end
    w_carry = w_s2_g | (w_s2_p & {WIDTH{r_s1_c0}});
    w_diff  = r_s1_p1 ^ {w_carry[WIDTH-2:0], r_s1_c0};
    w_bo    = ~{w_carry, r_s1_c0};
    w_zero  = ~|w_diff;
    w_ovf   = (r_s1_amsb ^ r_s1_bmsb) & (w_diff[WIDTH-1] ^ r_s1_amsb);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
      r_s2_diff  <= '0;
      r_s2_bo    <= '0;
      r_s2_zero  <= 1'b0;
      r_s2_ovf   <= 1'b0;
    end else if (w_s1_adv) begin
      r_s2_valid <= 1'b1;
      r_s2_diff  <= w_diff;
      r_s2_bo    <= w_bo;
      r_s2_zero  <= w_zero;
      r_s2_ovf   <= w_ovf;
    end else if (bus.out_ready) begin
      r_s2_valid <= 1'b0;
    end
  end

  assign bus.in_ready   = w_in_ready;
  assign bus.out_valid  = r_s2_valid;
  assign bus.Diff       = r_s2_diff;
  assign bus.Borrow_Out = r_s2_bo;
  assign bus.Zero       = r_s2_zero;
  assign bus.Overflow   = r_s2_ovf;
endmodule

// File: tb/tb_sklansky_subtractor_pipe.sv
// Bench for sklansky_subtractor_pipe: directed boundary beats, backpressure, mid-flight
// reset and random traffic, scored against an arithmetic A - B - Borrow_in model.
module tb_sklansky_subtractor_pipe;
  localparam int W  = 16;
  localparam int EW = 2 * W + 3;
  localparam int N_RANDOM = 4000;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  sklansky_subtractor_pipe_if #(.WIDTH(W)) bus ();
  sklansky_subtractor_pipe #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  logic [EW-1:0] exp_q[$];
  int            n_checks = 0;
  int            n_fail   = 0;
  logic          stalled  = 1'b0;
  logic [EW-1:0] held;

  // Expected result packed as {Diff, Borrow_Out, Zero, Overflow}.
  function automatic logic [EW-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic bin);
    logic [W:0]   full, bo, mask, am, bm;
    logic [W-1:0] d;
    logic         z, o;
    full  = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bin};
    d     = full[W-1:0];
    bo    = '0;
    bo[0] = bin;
    for (int k = 1; k <= W; k++) begin
      mask  = ({{W{1'b0}}, 1'b1} << k) - 1'b1;
      am    = {1'b0, a} & mask;
      bm    = ({1'b0, b} & mask) + {{W{1'b0}}, bin};
      bo[k] = (am < bm);
    end
    z = (d == '0);
    o = (a[W-1] != b[W-1]) && (d[W-1] != a[W-1]);
    return {d, bo, z, o};
  endfunction

  function automatic logic [EW-1:0] dut_out();
    return {bus.Diff, bus.Borrow_Out, bus.Zero, bus.Overflow};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: bound expired or unexpected event", name);
  endtask

  // Scoreboard: outputs and handshakes sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        check("stall_valid", bus.out_valid, 1);
        check("stall_hold", dut_out(), held);
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) fail_now("unexpected_out");
        else check("result", dut_out(), exp_q.pop_front());
      end
      stalled = bus.out_valid && !bus.out_ready;
      held    = dut_out();
      if (bus.in_valid && bus.in_ready)
        exp_q.push_back(model(bus.A, bus.B, bus.Borrow_in));
    end
  end

  task automatic send_beat(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
    bit acc;
    acc = 1'b0;
    bus.A = a;
    bus.B = b;
    bus.Borrow_in = bin;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 200 && !acc; i++) begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
    end
    if (!acc) fail_now("send_timeout");
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 100 && !done; i++) begin
      @(posedge clk);
      #2;
      done = (exp_q.size() == 0) && !bus.out_valid;
    end
    if (!done) fail_now("drain_timeout");
  endtask

  initial begin
    logic [EW-1:0] m;
    int sent;
    bus.in_valid  = 1'b0;
    bus.A         = '0;
    bus.B         = '0;
    bus.Borrow_in = 1'b0;
    bus.out_ready = 1'b1;

    m = model(16'h1234, 16'h0234, 1'b0);
    check("model_1234", m, {16'h1000, 17'h00000, 1'b0, 1'b0});
    m = model(16'h0000, 16'h0001, 1'b0);
    check("model_0m1", m, {16'hFFFF, 17'h1FFFE, 1'b0, 1'b0});
    m = model(16'h8000, 16'h0001, 1'b0);
    check("model_ovf", m, {16'h7FFF, 17'h0FFFE, 1'b0, 1'b1});
    m = model(16'h5555, 16'h5554, 1'b1);
    check("model_zero", m, {16'h0000, 17'h00001, 1'b1, 1'b0});

    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_outputs", dut_out(), 0);
    #2 rst_n = 1'b1;

    // First beat: latency and literal result.
    @(posedge clk);
    #1;
    bus.A = 16'h1234; bus.B = 16'h0234; bus.Borrow_in = 1'b0; bus.in_valid = 1'b1;
    @(negedge clk);
    check("first_accept_ready", bus.in_ready, 1);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    @(negedge clk);
    check("latency_cycle1", bus.out_valid, 0);
    @(posedge clk);
    @(negedge clk);
    check("latency_cycle2", bus.out_valid, 1);
    check("first_diff", bus.Diff, 16'h1000);
    check("first_borrow16", bus.Borrow_Out[W], 0);
    check("first_flags", {bus.Zero, bus.Overflow}, 2'b00);
    @(posedge clk);
    #1;

    send_beat(16'h0000, 16'h0001, 1'b0);
    send_beat(16'h8000, 16'h0001, 1'b0);
    send_beat(16'h5555, 16'h5554, 1'b1);
    send_beat(16'hFFFF, 16'hFFFF, 1'b0);
    drain();

    // Backpressure: five beats against a 4-cycle out_ready stall.
    fork
      begin
        send_beat(16'h0010, 16'h0003, 1'b0);
        send_beat(16'h7FFF, 16'hFFFF, 1'b0);
        send_beat(16'hABCD, 16'h1234, 1'b1);
        send_beat(16'h0000, 16'h0000, 1'b1);
        send_beat(16'hC000, 16'h4000, 1'b0);
        bus.in_valid = 1'b0;
      end
      begin
        bus.out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("bp_ready_one_full", bus.in_ready, 1);
        @(posedge clk);
        @(negedge clk);
        check("bp_ready_both_full", bus.in_ready, 0);
        check("bp_out_valid", bus.out_valid, 1);
        @(posedge clk);
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
      end
    join
    drain();

    // Reset with two beats in flight.
    bus.out_ready = 1'b0;
    send_beat(16'h1111, 16'h0001, 1'b0);
    send_beat(16'h2222, 16'h0002, 1'b0);
    bus.in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", bus.out_valid, 0);
    check("midrst_in_ready", bus.in_ready, 1);
    exp_q.delete();
    @(posedge clk);
    #3 rst_n = 1'b1;
    bus.out_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("midrst_no_stale", bus.out_valid, 0);

    // Random traffic.
    sent = 0;
    for (int c = 0; c < 20 * N_RANDOM && sent < N_RANDOM; c++) begin
      @(posedge clk);
      #1;
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.A         = W'($urandom);
      bus.B         = ($urandom_range(0, 7) == 0) ? bus.A : W'($urandom);
      bus.Borrow_in = 1'($urandom_range(0, 1));
      bus.out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (bus.in_valid && bus.in_ready) sent++;
    end
    if (sent < N_RANDOM) fail_now("random_budget");
    @(posedge clk);
    #1;
    drain();
    check("final_queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
